// File: rtl/class_assoc_search_if.sv
// Read bus and control/result signals of the HDC associative search stage.
// master = search engine, slave = class memory / query buffer / controller side.
interface class_assoc_search_if #(
  parameter int SEG_W   = 100,
  parameter int SCORE_W = 10
);
  logic               en;
  logic               start_infer;
  logic               class_gen_done;
  logic               rd_en;
  logic [4:0]         class_idx;
  logic [3:0]         seg_idx;
  logic [SEG_W-1:0]   class_seg;
  logic [SEG_W-1:0]   query_seg;
  logic               busy;
  logic               infer_done;
  logic [4:0]         pred_class;
  logic [SCORE_W-1:0] pred_score;

  modport master (
    input  en, start_infer, class_gen_done, class_seg, query_seg,
    output rd_en, class_idx, seg_idx, busy, infer_done, pred_class, pred_score
  );

  modport slave (
    output en, start_infer, class_gen_done, class_seg, query_seg,
    input  rd_en, class_idx, seg_idx, busy, infer_done, pred_class, pred_score
  );
endinterface

// File: rtl/class_assoc_search.sv
// Sparse HDC inference: streams query/class segments, scores each class by
// popcount(query AND class) and reports the highest-scoring class.
module class_assoc_search #(
  parameter int NUM_CLASSES = 26,
  parameter int SEG_COUNT   = 10,
  parameter int SEG_W       = 100,
  parameter int SCORE_W     = $clog2(SEG_W*SEG_COUNT+1)
) (
  input logic                  clk,
  input logic                  nrst,
  class_assoc_search_if.master bus
);

  localparam int         PC_W     = $clog2(SEG_W+1);
  localparam logic [3:0] SEG_LAST = 4'(SEG_COUNT-1);
  localparam logic [4:0] CLS_LAST = 5'(NUM_CLASSES-1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  function automatic logic [PC_W-1:0] popcount(input logic [SEG_W-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < SEG_W; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

  state_t             state;
  logic               rd_en, busy, infer_done;
  logic [4:0]         class_idx, pred_class, best_class;
  logic [3:0]         seg_idx;
  logic [SCORE_W-1:0] pred_score, best_score, acc;
  logic               start_ok;

  logic               vld_p1, last_p1;
  logic [4:0]         class_p1;
  logic [PC_W-1:0]    pc_p1;
  logic [SCORE_W-1:0] total_p1;
  logic               win_p1;
  logic [SCORE_W-1:0] best_score_nxt;
  logic [4:0]         best_class_nxt;

  assign start_ok = (state == S_IDLE) && bus.en && bus.start_infer && bus.class_gen_done;

  // Address sequencer and control FSM; a read issued while en drops still
  // advances the address, then the address holds until en returns.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      rd_en      <= 1'b0;
      class_idx  <= '0;
      seg_idx    <= '0;
      busy       <= 1'b0;
      infer_done <= 1'b0;
      pred_class <= '0;
      pred_score <= '0;
    end else begin
      infer_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state     <= S_SCAN;
            class_idx <= '0;
            seg_idx   <= '0;
            rd_en     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_SCAN: begin
          if (rd_en) begin
            if (seg_idx == SEG_LAST) begin
              if (class_idx == CLS_LAST) begin
                state <= S_DRAIN;
                rd_en <= 1'b0;
              end else begin
                seg_idx   <= '0;
                class_idx <= class_idx + 5'd1;
                rd_en     <= bus.en;
              end
            end else begin
              seg_idx <= seg_idx + 4'd1;
              rd_en   <= bus.en;
            end
          end else begin
            rd_en <= bus.en;
          end
        end
        S_DRAIN: begin
          // Final comparison lands this cycle, so take the post-compare winner.
          state      <= S_DONE;
          infer_done <= 1'b1;
          pred_class <= best_class_nxt;
          pred_score <= best_score_nxt;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: memory data returns; score and class-boundary compare.
  always_comb begin
    pc_p1          = popcount(bus.query_seg & bus.class_seg);
    total_p1       = acc + SCORE_W'(pc_p1);
    win_p1         = vld_p1 && last_p1 && (total_p1 > best_score);
    best_score_nxt = win_p1 ? total_p1 : best_score;
    best_class_nxt = win_p1 ? class_p1 : best_class;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      class_p1   <= '0;
      acc        <= '0;
      best_score <= '0;
      best_class <= '0;
    end else begin
      vld_p1   <= rd_en;
      last_p1  <= (seg_idx == SEG_LAST);
      class_p1 <= class_idx;
      if (start_ok) begin
        acc        <= '0;
        best_score <= '0;
        best_class <= '0;
      end else if (vld_p1) begin
        best_score <= best_score_nxt;
        best_class <= best_class_nxt;
        acc        <= last_p1 ? '0 : total_p1;
      end
    end
  end

  assign bus.rd_en      = rd_en;
  assign bus.class_idx  = class_idx;
  assign bus.seg_idx    = seg_idx;
  assign bus.busy       = busy;
  assign bus.infer_done = infer_done;
  assign bus.pred_class = pred_class;
  assign bus.pred_score = pred_score;

endmodule
